bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Two-master, one-slave arbiter for the shared memory-mapped bus (RAM, LED, UART TX/RX window).
Master 0 is the CPU data port; master 1 is a second requester, such as a UART boot-loader or DMA engine.
The block serialises requests, issues exactly one single-cycle slave strobe per transaction, and waits for the read acknowledge.
A timeout stops a missing acknowledge from hanging the CPU.

Parameters:
ADDR_W, 32, address width for both masters and the slave
DATA_W, 32, data width
TIMEOUT, 255, read-wait cycles before a forced acknowledge (minimum 1)
FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = master 0 always wins

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 request; held high until m0_ack
m0_write  in  1  master 0: 1 = write, 0 = read
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_rdata  out  DATA_W  master 0 read data; valid while m0_ack=1
m0_ack  out  1  master 0 completion pulse (1 cycle)
m1_req, m1_write, m1_addr, m1_wdata, m1_rdata, m1_ack  same as master 0, for master 1
s_en  out  1  slave strobe; exactly 1 cycle per transaction
s_write  out  1  slave write qualifier
s_addr  out  ADDR_W  slave address (registered)
s_wdata  out  DATA_W  slave write data (registered)
s_rdata  in  DATA_W  slave read data
s_ack  in  1  slave read acknowledge
grant  out  1  index of the master owning the bus; valid when busy=1
busy  out  1  1 in every state except IDLE
bus_err  out  1  sticky timeout flag
err_clr  in  1  synchronous clear of bus_err

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; all outputs 0.
  - Round-robin pointer set so that master 0 wins the first contention.
  - A transaction in flight is abandoned: no ack, no s_en.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, select a winner.
  - FIXED_PRIO=1: master 0 wins.
  - FIXED_PRIO=0: if both request, the master not granted last time wins.
  - Latch the winner's addr/wdata/write into s_addr/s_wdata/s_write, set grant, go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE (s_en=1 for this cycle only):
  - Write: pulse ack to the granted master next cycle (during DONE).
  - Read with s_ack=1 this same cycle: capture s_rdata, then as for a write.
  - Read with s_ack=0: go to WAIT and clear the timer.
- WAIT:
  - s_en=0; timer increments each cycle.
  - On s_ack: capture s_rdata, go to DONE.
  - If the timer reaches TIMEOUT without s_ack: go to DONE with rdata forced to 0 and set bus_err.
- DONE:
  - Granted master's ack=1 and rdata=captured value, for one cycle.
  - Update the round-robin pointer, return to IDLE.
  - The returning IDLE cycle ignores nothing: the master must drop req in the cycle after ack, so IDLE sees the fresh req value.
- Latency from IDLE with req high:
  - Write: ack 2 cycles later.
  - Read with combinational s_ack: ack 2 cycles later.
  - Read with an N-cycle slave: ack N+2 cycles later.
- Non-granted master: its req is ignored until IDLE; its ack and rdata stay 0; rdata of a master is 0 whenever its ack is 0.
- s_ack seen in IDLE or DONE: ignored.
- err_clr and a timeout in the same cycle: set wins.
- Master inputs changing after the IDLE latch: no effect on the current transaction.
- Timer width: clog2(TIMEOUT+1).

Decomposition:
- Shared package: state encoding enum (IDLE/ISSUE/WAIT/DONE) and the MASTER_CPU=0 / MASTER_AUX=1 constants.
- One natural sub-module, rr_pick: 2-input round-robin selector (req[1:0], last grant -> grant, valid).
- Everything else is inline.

Test Plan:
- Reset mid-WAIT: m0 read, slave silent, assert rst at WAIT cycle 3 -> s_en=0, busy=0, m0_ack never pulses, bus_err=0.
- Single write: m0 writes addr 0x400, data 0x2A -> s_en high for exactly 1 cycle with s_addr=0x400 and s_wdata=0x2A; m0_ack one cycle later; total 2 cycles from req.
- Read, slave acks after 3 cycles with 0xDEADBEEF -> m0_rdata=0xDEADBEEF while m0_ack=1, ack 5 cycles after req; m1_ack stays 0.
- Contention, FIXED_PRIO=0, both requesting continuously for 4 transactions -> grants alternate 0,1,0,1; FIXED_PRIO=1 -> all 4 go to m0 while m0 keeps requesting.
- Timeout with TIMEOUT=4, read with no s_ack -> ack after 4 WAIT cycles with rdata=0, bus_err=1 and sticky; err_clr pulse -> bus_err=0.
- Combinational-ack read (s_ack=1 during ISSUE, s_rdata=0x55) -> no WAIT state, ack 2 cycles after req with 0x55; exactly one s_en pulse per transaction across 10 back-to-back reads.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_pkg
//  Description : Shared types and constants for the two-master bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  // Arbiter transaction sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Master indices as they appear on the grant output
  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_AUX = 1'b1;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_rr_pick
//  Description : Two-input round-robin selector. On contention the master
//                that did not win last time is chosen.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       valid_o
);

  // Pick the sole requester, or alternate away from the last winner
  always_comb begin
    valid_o = |req_i;
    grant_o = MASTER_CPU;
    case (req_i)
      2'b01:   grant_o = MASTER_CPU;
      2'b10:   grant_o = MASTER_AUX;
      2'b11:   grant_o = ~last_i;
      default: grant_o = MASTER_CPU;
    endcase
  end

endmodule : bus_arbiter_rr_pick
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Two-master / one-slave bus arbiter. Serialises requests,
//                issues one single-cycle slave strobe per transaction, waits
//                for the read acknowledge with a timeout, and returns a
//                one-cycle ack with read data to the granted master.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 255,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              s_en,
  output logic              s_write,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack,
  output logic              grant,
  output logic              busy,
  output logic              bus_err,
  input  logic              err_clr
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              swrite_q, swrite_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [DATA_W-1:0] swdata_q, swdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;
  logic              err_set;

  logic              pick_last;
  logic              pick_grant;
  logic              pick_valid;

  // Fixed priority is round-robin with the AUX master permanently "last",
  // so the CPU always wins contention.
  assign pick_last = (FIXED_PRIO != 0) ? MASTER_AUX : last_q;

  bus_arbiter_rr_pick u_rr_pick (
    .req_i   ({m1_req, m0_req}),
    .last_i  (pick_last),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= MASTER_CPU;
      last_q   <= MASTER_AUX;
      swrite_q <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= '0;
      rdata_q  <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      swrite_q <= swrite_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      rdata_q  <= rdata_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: latch winner, strobe slave, wait/timeout, ack
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    swrite_d = swrite_q;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    rdata_d  = rdata_q;
    timer_d  = timer_q;
    err_set  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_grant;
          swrite_d = pick_grant ? m1_write : m0_write;
          saddr_d  = pick_grant ? m1_addr  : m0_addr;
          swdata_d = pick_grant ? m1_wdata : m0_wdata;
          rdata_d  = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (swrite_q) begin
          state_d = ST_DONE;
        end else if (s_ack) begin
          rdata_d = s_rdata;
          state_d = ST_DONE;
        end else begin
          timer_d = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_ack) begin
          rdata_d = s_rdata;
          state_d = ST_DONE;
        end else if (timer_q == TMR_LAST) begin
          rdata_d = '0;
          err_set = 1'b1;
          state_d = ST_DONE;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky timeout flag; a timeout in the same cycle as a clear wins
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  assign s_en     = (state_q == ST_ISSUE);
  assign s_write  = swrite_q;
  assign s_addr   = saddr_q;
  assign s_wdata  = swdata_q;
  assign grant    = grant_q;
  assign busy     = (state_q != ST_IDLE);
  assign bus_err  = err_q;
  assign m0_ack   = (state_q == ST_DONE) && (grant_q == MASTER_CPU);
  assign m1_ack   = (state_q == ST_DONE) && (grant_q == MASTER_AUX);
  assign m0_rdata = m0_ack ? rdata_q : '0;
  assign m1_rdata = m1_ack ? rdata_q : '0;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Directed self-checking bench for bus_arbiter (round-robin
//                and fixed-priority instances, TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          m0_req, m0_write, m1_req, m1_write;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ack, err_clr;

  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ack, m1_ack, s_en, s_write, grant, busy, bus_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;

  logic [DW-1:0] fp_m0_rdata, fp_m1_rdata;
  logic          fp_m0_ack, fp_m1_ack, fp_s_en, fp_s_write, fp_grant, fp_busy, fp_bus_err;
  logic [AW-1:0] fp_s_addr;
  logic [DW-1:0] fp_s_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .s_en(s_en), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(grant), .busy(busy), .bus_err(bus_err), .err_clr(err_clr)
  );

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(fp_m0_rdata), .m0_ack(fp_m0_ack),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(fp_m1_rdata), .m1_ack(fp_m1_ack),
    .s_en(fp_s_en), .s_write(fp_s_write), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack),
    .grant(fp_grant), .busy(fp_busy), .bus_err(fp_bus_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int en_cnt, ack_cnt, bad_cnt, k, m1_cnt;
    logic [AW-1:0] exp_addr;
    logic [3:0] exp_g;

    rst = 1'b1;
    m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
    s_rdata = '0; s_ack = 0; err_clr = 0;

    tick(1);
    check("rst_s_en",   s_en,    1'b0);
    check("rst_busy",   busy,    1'b0);
    check("rst_ack",    m0_ack,  1'b0);
    check("rst_err",    bus_err, 1'b0);
    check("rst_saddr",  s_addr,  '0);
    tick(1);
    rst = 1'b0;

    // ---- Reset in the middle of WAIT ----
    m0_req = 1; m0_write = 0; m0_addr = 32'h100;
    tick(1);
    check("rw_issue", s_en, 1'b1);
    tick(3);
    check("rw_wait_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rw_s_en", s_en, 1'b0);
    check("rw_busy", busy, 1'b0);
    check("rw_ack",  m0_ack, 1'b0);
    check("rw_err",  bus_err, 1'b0);
    m0_req = 0;
    tick(2);
    check("rw_ack_hold", m0_ack, 1'b0);
    rst = 1'b0;
    tick(1);
    check("rw_idle", busy, 1'b0);

    // ---- Single write ----
    m0_req = 1; m0_write = 1; m0_addr = 32'h400; m0_wdata = 32'h2A;
    tick(1);
    check("wr_s_en",   s_en,    1'b1);
    check("wr_saddr",  s_addr,  32'h400);
    check("wr_swdata", s_wdata, 32'h2A);
    check("wr_swrite", s_write, 1'b1);
    check("wr_grant",  grant,   1'b0);
    check("wr_ack_early", m0_ack, 1'b0);
    m0_addr = 32'hFFF; m0_wdata = 32'h77;
    tick(1);
    check("wr_s_en_off", s_en,   1'b0);
    check("wr_ack",      m0_ack, 1'b1);
    check("wr_m1_ack",   m1_ack, 1'b0);
    check("wr_saddr_held", s_addr, 32'h400);
    m0_req = 0;
    tick(1);
    check("wr_ack_off", m0_ack, 1'b0);
    check("wr_idle",    busy,   1'b0);

    // ---- Read, slave answers in the third WAIT cycle ----
    m0_req = 1; m0_write = 0; m0_addr = 32'h10; s_rdata = 32'hDEADBEEF;
    tick(4);
    check("rd_ack_early", m0_ack, 1'b0);
    check("rd_rdata_zero", m0_rdata, 32'h0);
    s_ack = 1;
    tick(1);
    check("rd_ack",    m0_ack,   1'b1);
    check("rd_rdata",  m0_rdata, 32'hDEADBEEF);
    check("rd_m1_ack", m1_ack,   1'b0);
    check("rd_m1_rdata", m1_rdata, 32'h0);
    s_ack = 0; m0_req = 0;
    tick(1);
    check("rd_rdata_after", m0_rdata, 32'h0);

    // ---- Timeout (TIMEOUT=4) ----
    m0_req = 1; m0_write = 0; s_rdata = 32'h1234;
    tick(5);
    check("to_ack_early", m0_ack,  1'b0);
    check("to_err_early", bus_err, 1'b0);
    tick(1);
    check("to_ack",   m0_ack,   1'b1);
    check("to_rdata", m0_rdata, 32'h0);
    check("to_err",   bus_err,  1'b1);
    m0_req = 0;
    tick(3);
    check("to_sticky", bus_err, 1'b1);
    err_clr = 1;
    tick(1);
    err_clr = 0;
    check("to_clr", bus_err, 1'b0);

    // Clear held through a timeout: the set wins
    m0_req = 1; err_clr = 1;
    tick(5);
    check("to_clr_hold", bus_err, 1'b0);
    tick(1);
    check("to_set_wins", bus_err, 1'b1);
    err_clr = 0; m0_req = 0;
    tick(1);

    // ---- Combinational-ack reads, back to back ----
    s_ack = 1; s_rdata = 32'h55; m0_req = 1; m0_write = 0;
    en_cnt = 0; ack_cnt = 0; bad_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (i == 1) check("ca_issue", s_en, 1'b1);
      if (i == 2) check("ca_ack_lat", m0_ack, 1'b1);
      if (s_en) en_cnt++;
      if (m0_ack) begin
        ack_cnt++;
        if (m0_rdata !== 32'h55) bad_cnt++;
      end
      if (m1_ack) bad_cnt++;
    end
    m0_req = 0; s_ack = 0;
    check("ca_s_en_count", en_cnt,  10);
    check("ca_ack_count",  ack_cnt, 10);
    check("ca_bad_data",   bad_cnt, 0);
    tick(2);

    // ---- Contention, both masters writing continuously ----
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m0_req = 1; m0_write = 1; m0_addr = 32'hA0; m0_wdata = 32'h1;
    m1_req = 1; m1_write = 1; m1_addr = 32'hB0; m1_wdata = 32'h2;
    exp_g = 4'b1010;   // bit k = expected round-robin grant of transaction k
    k = 0; m1_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (s_en && k < 4) begin
        exp_addr = exp_g[k] ? 32'hB0 : 32'hA0;
        check($sformatf("rr_grant%0d", k), grant, exp_g[k]);
        check($sformatf("rr_addr%0d", k), s_addr, exp_addr);
        check($sformatf("fp_s_en%0d", k), fp_s_en, 1'b1);
        check($sformatf("fp_grant%0d", k), fp_grant, 1'b0);
        check($sformatf("fp_addr%0d", k), fp_s_addr, 32'hA0);
        k++;
      end
      if (m1_ack) m1_cnt++;
    end
    m0_req = 0; m1_req = 0;
    check("rr_txn_count", k, 4);
    check("rr_m1_acks", m1_cnt, 2);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire
